// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared shifter modes, command opcodes and FSM encodings for shift_sequencer.
`default_nettype none

package shift_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_sequencer.sv
// shift_sequencer: runs one load/shift/read command at a time on a universal_shifter
// and returns the shifter contents on a valid/ready response channel.
`default_nettype none

module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sh_mode,
  output logic [WIDTH-1:0] sh_data_in,
  input  logic [WIDTH-1:0] sh_data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  import shift_seq_pkg::*;

  state_t           state;
  logic [1:0]       op;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      op    <= OP_READ;
      amt   <= '0;
      data  <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op    <= cmd_op;
            amt   <= cmd_amt;
            data  <= cmd_data;
            state <= (cmd_op == OP_READ) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if ((op == OP_SHR || op == OP_SHL) && amt != '0) begin
            count <= amt;
            state <= ST_SHIFT;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Everything below decodes from registers, so reset forces the shifter to hold at once.
  always_comb begin
    sh_mode = MODE_HOLD;
    case (state)
      ST_LOAD:  sh_mode = MODE_LOAD;
      ST_SHIFT: sh_mode = (op == OP_SHL) ? MODE_SHL : MODE_SHR;
      default:  sh_mode = MODE_HOLD;
    endcase
  end

  assign sh_data_in = data;
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign rsp_valid  = (state == ST_DONE);
  assign rsp_data   = sh_data_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven, reset-abort and random checks of shift_sequencer
// driving a zero-fill registered shifter model.
`default_nettype none

module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       sh_mode;
  logic [WIDTH-1:0] sh_data_in;
  logic [WIDTH-1:0] sh_data_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] model_reg;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .sh_mode(sh_mode), .sh_data_in(sh_data_in), .sh_data_out(sh_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  // Zero-fill universal shifter standing in for the real block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sh_data_out <= '0;
    else begin
      case (sh_mode)
        2'b01:   sh_data_out <= sh_data_out >> 1;
        2'b10:   sh_data_out <= sh_data_out << 1;
        2'b11:   sh_data_out <= sh_data_in;
        default: sh_data_out <= sh_data_out;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op, input int amt,
                                                  input logic [WIDTH-1:0] data);
    int unsigned v;
    v = data;
    case (op)
      2'b00:   return model_reg;
      2'b01:   v = v >> amt;
      2'b10:   v = v << amt;
      default: v = data;
    endcase
    return v[WIDTH-1:0];
  endfunction

  // Called at a falling edge with the controller idle.
  task automatic do_cmd(input logic [1:0] op, input logic [CNT_W-1:0] amt,
                        input logic [WIDTH-1:0] data, input int stall, input bit hold_next,
                        input logic [WIDTH-1:0] exp_data);
    logic [1:0] q[$];
    int lat;
    int cyc;
    logic [1:0] exp_mode;
    logic [WIDTH-1:0] held;
    if (op != 2'b00) q.push_back(2'b11);
    if (op == 2'b01 || op == 2'b10)
      for (int i = 0; i < int'(amt); i++) q.push_back(op);
    lat = (op == 2'b00) ? 1 : q.size() + 1;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data;
    rsp_ready = (stall == 0);
    @(posedge clk);
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cmd_valid = 1'b0;
      exp_mode = (cyc <= q.size()) ? q[cyc-1] : 2'b00;
      check("sh_mode", sh_mode, exp_mode);
      check("busy", busy, 1);
      check("cmd_ready_busy", cmd_ready, 0);
      if (rsp_valid) break;
    end
    check("latency", cyc, lat);
    check("rsp_data", rsp_data, exp_data);
    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      if (hold_next && s == 0) begin
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_amt = '0; cmd_data = '1;
      end
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, held);
      check("stall_mode", sh_mode, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_ready", cmd_ready, 1);
    check("post_rsp_valid", rsp_valid, 0);
    model_reg = exp_data;
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] data;
    int               stall;
    bit               hold;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'b11, 3'd0, 4'b1100, 0, 1'b0, 4'b1100};
    vecs[1] = '{2'b01, 3'd2, 4'b1100, 0, 1'b0, 4'b0011};
    vecs[2] = '{2'b10, 3'd1, 4'b0011, 5, 1'b1, 4'b0110};
    vecs[3] = '{2'b00, 3'd0, 4'b0000, 0, 1'b0, 4'b0110};
    vecs[4] = '{2'b01, 3'd0, 4'b1010, 0, 1'b0, 4'b1010};
    vecs[5] = '{2'b10, 3'd7, 4'b0001, 0, 1'b0, 4'b0000};
    vecs[6] = '{2'b01, 3'd5, 4'b1111, 2, 1'b0, 4'b0000};
    vecs[7] = '{2'b11, 3'd3, 4'b1001, 1, 1'b0, 4'b1001};
    vecs[8] = '{2'b00, 3'd0, 4'b0000, 0, 1'b0, 4'b1001};

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_data = '0;
    rsp_ready = 1'b1; model_reg = '0;
    #12;
    check("rst_sh_mode", sh_mode, 0);
    check("rst_sh_data_in", sh_data_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_cmd(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].stall, vecs[i].hold, vecs[i].exp);

    // Abort a long SHL in its third cycle.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_amt = 3'd7; cmd_data = 4'b0011;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_mode", sh_mode, 2'b10);
    reset = 1'b0;
    #1;
    check("abort_mode", sh_mode, 0);
    check("abort_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reg = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
    end
    do_cmd(2'b00, 3'd0, 4'b0000, 0, 1'b0, 4'b0000);
    do_cmd(2'b10, 3'd2, 4'b0101, 1, 1'b0, 4'b0100);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]       op;
      logic [CNT_W-1:0] amt;
      logic [WIDTH-1:0] data;
      op   = 2'($urandom_range(0, 3));
      amt  = CNT_W'($urandom_range(0, 7));
      data = WIDTH'($urandom);
      do_cmd(op, amt, data, int'($urandom_range(0, 3)), 1'b0, ref_result(op, int'(amt), data));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sequences a universal_shifter (mode[1:0], data_in, data_out).
- Accepts one shift command per valid/ready handshake: load a word, shift it left or right N times, or read back current contents.
- Drives the shifter's mode and data_in cycle by cycle, then returns the shifter output on a response valid/ready channel.
- Sits beside the shifter at parent level. Upstream logic never drives shifter modes directly.

Parameters:
- WIDTH, 4, data width; must match the shifter.
- CNT_W, 3, width of the shift-amount field (max amount 2^CNT_W-1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 READ, 01 SHR, 10 SHL, 11 LOAD.
- cmd_amt  in  CNT_W  shift count; SHR/SHL only.
- cmd_data  in  WIDTH  word to load; ignored for READ.
- sh_mode  out  2  to shifter: 00 hold, 01 shift right, 10 shift left, 11 load.
- sh_data_in  out  WIDTH  to shifter data_in.
- sh_data_out  in  WIDTH  from shifter data_out (registered in the shifter).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  result word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE. Outputs are decoded from the state register, the latched op and the latched data.
- Reset (reset=0, asynchronous):
  - state=IDLE; op/amt/data/count registers=0.
  - sh_mode=00, sh_data_in=0, rsp_valid=0, busy=0.
  - cmd_ready reads 1, since it is decoded as state==IDLE. Drivers must keep cmd_valid low during reset.
- IDLE: cmd_ready=1, sh_mode=00. On cmd_valid&cmd_ready, latch op, amt and data. Next state:
  - READ -> DONE.
  - All other ops -> LOAD.
- LOAD (exactly 1 cycle): sh_mode=11, sh_data_in=latched data. Next state:
  - SHR/SHL with amt!=0 -> SHIFT, with count=amt.
  - Otherwise (LOAD op, or amt==0) -> DONE.
- SHIFT: sh_mode=01 (SHR) or 10 (SHL). Count decrements each cycle; on the count==1 cycle the next state is DONE. Exactly amt shift cycles are issued.
- DONE: sh_mode=00 (shifter holds), rsp_valid=1, rsp_data=sh_data_out (combinational pass-through; stable because the shifter is holding). On rsp_valid&rsp_ready -> IDLE.
- Latency, counted from the acceptance edge:
  - READ: rsp_valid in cycle 1.
  - LOAD op, or shift with amt=0: rsp_valid in cycle 2.
  - SHR/SHL: rsp_valid in cycle amt+2.
- Throughput: one command in flight. cmd_ready=0 from acceptance through the response handshake, so the next command is accepted no earlier than the cycle after the rsp handshake.
- Backpressure: rsp_valid and rsp_data stay stable while rsp_ready=0, indefinitely.
- cmd_valid while busy is ignored (not latched). The driver must hold the command until it is accepted.
- amt > WIDTH is legal. The controller issues all amt shifts; the result depends on the shifter's fill policy.
- Reset mid-operation aborts the command immediately: no response, sh_mode=00 asynchronously.
- sh_data_in holds the last latched data outside LOAD. Its value is don't-care to the shifter except in mode 11.

Decomposition:
- Package shift_seq_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - op constants OP_READ/OP_SHR/OP_SHL/OP_LOAD;
  - FSM state encodings.
- No sub-module inside the controller.
- The bench and the parent instantiate universal_shifter alongside it, wired sh_mode->mode, sh_data_in->data_in, data_out->sh_data_out.

Test Plan:
- Reset, then LOAD op with data=1100, rsp_ready=1 -> sh_mode sequence 11,00; rsp_valid in cycle 2; rsp_data=1100; then back to IDLE with cmd_ready=1.
- SHR, amt=2, data=1100 -> sh_mode 11,01,01,00; rsp_valid in cycle 4; rsp_data equals the shifter contents (0011 with a zero-fill shifter); busy high for cycles 1-4.
- SHL, amt=1, data=0011, rsp_ready held low 5 cycles -> rsp_valid high and rsp_data (0110 zero-fill) stable for all 5 cycles; second cmd_valid during that time is not accepted; accepted the cycle after the handshake.
- READ after the previous test -> sh_mode stays 00, rsp_valid in cycle 1, rsp_data = last shifter value; SHR with amt=0, data=1010 -> rsp_data=1010 in cycle 2.
- Assert reset during SHIFT of SHL amt=7 (at cycle 3) -> sh_mode=00, rsp_valid=0, busy=0 immediately; no response after release; the next command completes normally.
